mat_switch: RTL

- Inter-core vector switch that sits directly between the MatCore switch ports.
- Consumes each core's send port (switch_send_*) and produces each core's receive port (switch_recv_*).
- Holds one single-entry mailbox per (source, destination) core pair, so transfers are decoupled rendezvous rather than synchronous handshakes between cores.
- Data is carried as raw 32-bit IEEE-754 words; the switch never interprets values.

---
 rtl/mat_switch.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mat_switch.sv
// mat_switch: inter-core vector switch between the MatCore switch ports.
// One single-entry mailbox per (source, destination) pair decouples senders
// from receivers. Each core has a send FSM {S_IDLE, S_ACK} and a recv FSM
// {R_IDLE, R_ACK}; send_ok / recv_ready are one-cycle pulses driven from the
// ACK states. Data words are carried raw and never interpreted.
//
// Optional feature: define MAT_SWITCH_BYPASS_EN to forward a same-cycle send
// straight to a waiting receiver of an empty mailbox (mailbox stays empty).
//
// Handshake: a send request (switch_send_ready) and its idx/data must stay
// stable until switch_send_ok pulses; a receive request (switch_recv_request)
// and its idx are held until switch_recv_ready pulses. Requests seen while the
// matching FSM is in its ACK state are ignored.
//
// Debug outputs expose both FSM state vectors (1 = ACK) and mailbox valid
// bits, indexed [src*SWITCH_CORE_SIZE + dst].

`timescale 1ns/1ps

module mat_switch #(
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_WIDTH          = 16,
    parameter int WORD_BITS             = 32,
    parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                           switch_send_ready,
    input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]     switch_send_core_idx,
    input  logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*WORD_BITS-1:0]    switch_send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                           switch_send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                           switch_recv_request,
    input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]     switch_recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                           switch_recv_ready,
    output logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*WORD_BITS-1:0]    switch_recv_data,
    output logic [SWITCH_CORE_SIZE-1:0]                           dbg_send_state,
    output logic [SWITCH_CORE_SIZE-1:0]                           dbg_recv_state,
    output logic [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE-1:0]          dbg_mbox_valid
);

    localparam int N   = SWITCH_CORE_SIZE;
    localparam int A   = SWITCH_CORE_ADDR_SIZE;
    localparam int VEC = SWITCH_WIDTH * WORD_BITS;

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} send_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_ACK = 1'b1} recv_state_t;

    send_state_t send_state      [N];
    send_state_t send_state_next [N];
    recv_state_t recv_state      [N];
    recv_state_t recv_state_next [N];

    // Mailboxes: rows indexed by source, bits/columns by destination.
    logic [N-1:0]   mbox_valid [N];
    logic [VEC-1:0] mbox_data  [N][N];
    logic [VEC-1:0] recv_data_q [N];

    // Unpacked views of the flattened port buses.
    logic [A-1:0]   send_idx [N];
    logic [A-1:0]   recv_idx [N];
    logic [VEC-1:0] send_vec [N];

    // Per-pair decode, all indexed [src][dst].
    logic [N-1:0]   wr_tgt     [N];
    logic [N-1:0]   rd_tgt     [N];
    logic [N-1:0]   drain      [N];
    logic [N-1:0]   bypass     [N];
    logic [N-1:0]   mbox_write [N];
    logic [N-1:0]   send_req;
    logic [N-1:0]   recv_req;
    logic [N-1:0]   accept;
    logic [N-1:0]   hit;
    logic [VEC-1:0] recv_next [N];

    // Split the flattened per-core buses into per-core fields.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            send_idx[c] = switch_send_core_idx[c*A +: A];
            recv_idx[c] = switch_recv_core_idx[c*A +: A];
            send_vec[c] = switch_send_data[c*VEC +: VEC];
        end
    end

    // Decode which mailboxes are written, drained or bypassed this cycle.
    // Out-of-range indices match no mailbox, so they never accept or hit.
    always_comb begin
        accept = '0;
        hit    = '0;
        for (int c = 0; c < N; c++) begin
            send_req[c]  = (send_state[c] == S_IDLE) && switch_send_ready[c];
            recv_req[c]  = (recv_state[c] == R_IDLE) && switch_recv_request[c];
            recv_next[c] = '0;
        end
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                wr_tgt[s][d] = send_req[s] && (send_idx[s] == A'(d));
                rd_tgt[s][d] = recv_req[d] && (recv_idx[d] == A'(s));
                drain[s][d]  = rd_tgt[s][d] && mbox_valid[s][d];
`ifdef MAT_SWITCH_BYPASS_EN
                bypass[s][d] = rd_tgt[s][d] && wr_tgt[s][d] && !mbox_valid[s][d];
`else
                bypass[s][d] = 1'b0;
`endif
                // A full mailbox accepts a new write only while being drained.
                accept[s] = accept[s] | (wr_tgt[s][d] && (!mbox_valid[s][d] || drain[s][d]));
                hit[d]    = hit[d] | drain[s][d] | bypass[s][d];
            end
        end
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                mbox_write[s][d] = wr_tgt[s][d] && accept[s] && !bypass[s][d];
                if (drain[s][d]) begin
                    recv_next[d] = mbox_data[s][d];
                end
                if (bypass[s][d]) begin
                    recv_next[d] = send_vec[s];
                end
            end
        end
    end

    // Mailbox valid bits: a write wins over a same-cycle drain (new data stays).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < N; s++) begin
                mbox_valid[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                for (int d = 0; d < N; d++) begin
                    if (mbox_write[s][d]) begin
                        mbox_valid[s][d] <= 1'b1;
                    end else if (drain[s][d]) begin
                        mbox_valid[s][d] <= 1'b0;
                    end
                end
            end
        end
    end

    // Mailbox payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clock) begin
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (mbox_write[s][d]) begin
                    mbox_data[s][d] <= send_vec[s];
                end
            end
        end
    end

    // Received vector per core, held until the next delivery.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                recv_data_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (hit[c]) begin
                    recv_data_q[c] <= recv_next[c];
                end
            end
        end
    end

    // FSM state registers for all send and recv FSMs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                send_state[c] <= S_IDLE;
                recv_state[c] <= R_IDLE;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                send_state[c] <= send_state_next[c];
                recv_state[c] <= recv_state_next[c];
            end
        end
    end

    // FSM next-state: ACK always lasts exactly one cycle.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            send_state_next[c] = S_IDLE;
            recv_state_next[c] = R_IDLE;
            if (send_state[c] == S_IDLE && accept[c]) begin
                send_state_next[c] = S_ACK;
            end
            if (recv_state[c] == R_IDLE && hit[c]) begin
                recv_state_next[c] = R_ACK;
            end
        end
    end

    // FSM outputs: pulses come straight from the ACK states.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            switch_send_ok[c]             = (send_state[c] == S_ACK);
            switch_recv_ready[c]          = (recv_state[c] == R_ACK);
            dbg_send_state[c]             = (send_state[c] == S_ACK);
            dbg_recv_state[c]             = (recv_state[c] == R_ACK);
            switch_recv_data[c*VEC +: VEC] = recv_data_q[c];
            for (int d = 0; d < N; d++) begin
                dbg_mbox_valid[c*N + d] = mbox_valid[c][d];
            end
        end
    end

endmodule
